videosync_gen: RTL and testbench
================================

Name: videosync_gen

Overview:
Parametrised horizontal/vertical timing generator for discrete-logic arcade cores. It owns its own H and V counters and produces HSYNC, HBLANK, VSYNC and VBLANK in both polarities from programmable compare windows. It adds a configurable HBLANK delay line, plus line and frame strobes. It replaces the per-board hard-wired sync gating and sits between the pixel-clock enable and the video output and mixer logic.

Parameters:
H_W, 9, width of horizontal counter
V_W, 9, width of vertical counter
H_TOTAL, 455, pixels per line; counter range is 0..H_TOTAL-1
V_TOTAL, 262, lines per frame; counter range is 0..V_TOTAL-1
H_BLANK_START, 0, first HCOUNT with HBLANK active
H_BLANK_END, 80, first HCOUNT with HBLANK inactive
H_SYNC_START, 32, first HCOUNT with HSYNC active
H_SYNC_END, 64, first HCOUNT with HSYNC inactive
V_BLANK_START, 0, first VCOUNT with VBLANK active
V_BLANK_END, 16, first VCOUNT with VBLANK inactive
V_SYNC_START, 12, first VCOUNT with VSYNC active
V_SYNC_END, 16, first VCOUNT with VSYNC inactive
HBLANK_DELAY, 5, CLK_DRV cycles of extra delay on HBLANK/HBLANK_N (0 = none)

Ports:
CLK_DRV  in  1  single design clock
RESET  in  1  asynchronous, active-high reset
CE_PIX  in  1  pixel clock enable; counters advance only when high
HCOUNT  out  H_W  current horizontal position
VCOUNT  out  V_W  current vertical position
HRESET  out  1  one-CLK_DRV pulse on the CE_PIX cycle where HCOUNT wraps to 0
VRESET  out  1  one-CLK_DRV pulse on the CE_PIX cycle where both counters wrap to 0
HSYNC, HSYNC_N  out  1 each  horizontal sync, true and complement
HBLANK, HBLANK_N  out  1 each  delayed horizontal blank, true and complement
VSYNC, VSYNC_N  out  1 each  vertical sync, true and complement
VBLANK, VBLANK_N  out  1 each  vertical blank, true and complement

Behaviour:
- Reset (async, while RESET=1):
  - HCOUNT=0, VCOUNT=0, HRESET=0, VRESET=0.
  - All active-high sync/blank outputs = 0; all _N outputs = 1.
  - Every delay-line stage clears to inactive (HBLANK 0, HBLANK_N 1).
- Counters, on CLK_DRV rising edge with CE_PIX=1:
  - HCOUNT = (HCOUNT==H_TOTAL-1) ? 0 : HCOUNT+1.
  - VCOUNT advances only when HCOUNT wraps, and wraps the same way at V_TOTAL-1.
  - With CE_PIX=0, counters and all flags hold; HRESET and VRESET are 0.
- Window rule for each flag, with window [START, END) taken modulo TOTAL:
  - START<END: active when START <= count < END.
  - START>END: the window wraps; active when count >= START or count < END.
  - START==END: flag is constantly inactive.
- Flag timing and alignment:
  - Flags are registered from the next-count value, so each flag is aligned with the HCOUNT/VCOUNT it describes (zero latency relative to the counter outputs).
  - V flags change only at the HCOUNT wrap.
  - Each _N output is the exact registered complement of its true output, never computed separately.
- HBLANK path:
  - The internal HBLANK is shifted through HBLANK_DELAY CLK_DRV-clocked stages.
  - The shift runs every CLK_DRV cycle, independent of CE_PIX.
  - HBLANK_DELAY=0 bypasses the delay.
  - HSYNC is not delayed.
- Reset released mid-frame: counting restarts at (0,0) on the first CE_PIX. HBLANK emerges HBLANK_DELAY cycles after its internal flag.
- Simultaneous wrap: HRESET and VRESET pulse on the same cycle. VCOUNT goes to 0 on that same edge as HCOUNT.
- Parameter checks (elaboration assertion): every START/END < TOTAL; H_TOTAL <= 2^H_W; V_TOTAL <= 2^V_W.

Test Plan:
- Reset, CE_PIX=1 for one full line (defaults) -> HCOUNT counts 0..454 then 0. HRESET pulses exactly once, at the 454->0 edge. VCOUNT goes 0->1.
- Default HSYNC -> high for HCOUNT 32..63, i.e. 32 pixels. HSYNC_N is the exact inverse on every cycle.
- HBLANK_DELAY=5 vs HBLANK_DELAY=0 -> delayed HBLANK rises 5 CLK_DRV cycles after HCOUNT=0 and falls 5 cycles after HCOUNT=80. With 0, it is aligned with the counter.
- Full frame (defaults) -> VBLANK high for VCOUNT 0..15. VSYNC high for VCOUNT 12..15 only. VRESET pulses once, coincident with HRESET, at (454,261)->(0,0).
- Wrapping window H_BLANK_START=440, H_BLANK_END=20 -> HBLANK active for HCOUNT 440..454 and 0..19. START==END -> flag never asserts.
- CE_PIX toggling 1-of-4, then RESET asserted at HCOUNT=100 -> counters advance once per 4 clocks. Reset forces outputs to reset values immediately (asynchronously). After release, counting restarts from 0.

Source files
------------

// File: rtl/videosync_gen.sv
// Horizontal/vertical timing generator: pixel-enabled H/V counters, windowed sync/blank flags,
// delayed HBLANK and line/frame wrap strobes. Flags are zero-latency relative to HCOUNT/VCOUNT.
module videosync_gen #(
  parameter int H_W           = 9,
  parameter int V_W           = 9,
  parameter int H_TOTAL       = 455,
  parameter int V_TOTAL       = 262,
  parameter int H_BLANK_START = 0,
  parameter int H_BLANK_END   = 80,
  parameter int H_SYNC_START  = 32,
  parameter int H_SYNC_END    = 64,
  parameter int V_BLANK_START = 0,
  parameter int V_BLANK_END   = 16,
  parameter int V_SYNC_START  = 12,
  parameter int V_SYNC_END    = 16,
  parameter int HBLANK_DELAY  = 5
) (
  input  logic           CLK_DRV,
  input  logic           RESET,
  input  logic           CE_PIX,
  output logic [H_W-1:0] HCOUNT,
  output logic [V_W-1:0] VCOUNT,
  output logic           HRESET,
  output logic           VRESET,
  output logic           HSYNC,
  output logic           HSYNC_N,
  output logic           HBLANK,
  output logic           HBLANK_N,
  output logic           VSYNC,
  output logic           VSYNC_N,
  output logic           VBLANK,
  output logic           VBLANK_N
);

  if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W)) begin : g_bad_total
    $error("videosync_gen: TOTAL does not fit in counter width");
  end
  if (H_BLANK_START >= H_TOTAL || H_BLANK_END >= H_TOTAL ||
      H_SYNC_START  >= H_TOTAL || H_SYNC_END  >= H_TOTAL) begin : g_bad_h
    $error("videosync_gen: horizontal window bound outside 0..H_TOTAL-1");
  end
  if (V_BLANK_START >= V_TOTAL || V_BLANK_END >= V_TOTAL ||
      V_SYNC_START  >= V_TOTAL || V_SYNC_END  >= V_TOTAL) begin : g_bad_v
    $error("videosync_gen: vertical window bound outside 0..V_TOTAL-1");
  end

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  // Window [s, e) with wrap-around when s > e; empty when s == e.
  function automatic logic in_win(input int c, input int s, input int e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  logic           h_wrap, v_wrap;
  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           hs_nx, hb_nx, vs_nx, vb_nx;
  logic           hb_int, hb_int_n;

  always_comb begin
    h_wrap = (HCOUNT == H_LAST);
    v_wrap = (VCOUNT == V_LAST);
    h_next = h_wrap ? '0 : HCOUNT + H_W'(1);
    v_next = VCOUNT;
    if (h_wrap) v_next = v_wrap ? '0 : VCOUNT + V_W'(1);
    hs_nx = in_win(int'(h_next), H_SYNC_START, H_SYNC_END);
    hb_nx = in_win(int'(h_next), H_BLANK_START, H_BLANK_END);
    vs_nx = in_win(int'(v_next), V_SYNC_START, V_SYNC_END);
    vb_nx = in_win(int'(v_next), V_BLANK_START, V_BLANK_END);
  end

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      HCOUNT   <= '0;
      VCOUNT   <= '0;
      HRESET   <= 1'b0;
      VRESET   <= 1'b0;
      HSYNC    <= 1'b0;
      HSYNC_N  <= 1'b1;
      hb_int   <= 1'b0;
      hb_int_n <= 1'b1;
      VSYNC    <= 1'b0;
      VSYNC_N  <= 1'b1;
      VBLANK   <= 1'b0;
      VBLANK_N <= 1'b1;
    end else begin
      HRESET <= CE_PIX && h_wrap;
      VRESET <= CE_PIX && h_wrap && v_wrap;
      if (CE_PIX) begin
        HCOUNT   <= h_next;
        VCOUNT   <= v_next;
        HSYNC    <= hs_nx;
        HSYNC_N  <= ~hs_nx;
        hb_int   <= hb_nx;
        hb_int_n <= ~hb_nx;
        VSYNC    <= vs_nx;
        VSYNC_N  <= ~vs_nx;
        VBLANK   <= vb_nx;
        VBLANK_N <= ~vb_nx;
      end
    end
  end

  // The delay line runs on every clock, not just pixel enables.
  if (HBLANK_DELAY == 0) begin : g_no_delay
    assign HBLANK   = hb_int;
    assign HBLANK_N = hb_int_n;
  end else begin : g_delay
    logic [HBLANK_DELAY-1:0] dl, dl_n;
    always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
        dl   <= '0;
        dl_n <= '1;
      end else begin
        dl   <= HBLANK_DELAY'({dl, hb_int});
        dl_n <= HBLANK_DELAY'({dl_n, hb_int_n});
      end
    end
    assign HBLANK   = dl[HBLANK_DELAY-1];
    assign HBLANK_N = dl_n[HBLANK_DELAY-1];
  end

endmodule

// File: tb/tb_videosync_gen.sv
// Directed bench for videosync_gen: default timing (delay 5), a delay-0 wrapping-window
// instance, and a small-frame instance used for full-frame vertical checks.
module tb_videosync_gen;
  logic clk = 1'b0;
  logic rst, ce;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] hc0, vc0, hc1, vc1, hc2, vc2;
  logic hr0, vr0, hs0, hsn0, hb0, hbn0, vs0, vsn0, vb0, vbn0;
  logic hr1, vr1, hs1, hsn1, hb1, hbn1, vs1, vsn1, vb1, vbn1;
  logic hr2, vr2, hs2, hsn2, hb2, hbn2, vs2, vsn2, vb2, vbn2;

  videosync_gen dut0 (
    .CLK_DRV(clk), .RESET(rst), .CE_PIX(ce), .HCOUNT(hc0), .VCOUNT(vc0),
    .HRESET(hr0), .VRESET(vr0), .HSYNC(hs0), .HSYNC_N(hsn0), .HBLANK(hb0),
    .HBLANK_N(hbn0), .VSYNC(vs0), .VSYNC_N(vsn0), .VBLANK(vb0), .VBLANK_N(vbn0));

  videosync_gen #(.HBLANK_DELAY(0), .H_BLANK_START(440), .H_BLANK_END(20),
                  .H_SYNC_START(100), .H_SYNC_END(100)) dut1 (
    .CLK_DRV(clk), .RESET(rst), .CE_PIX(ce), .HCOUNT(hc1), .VCOUNT(vc1),
    .HRESET(hr1), .VRESET(vr1), .HSYNC(hs1), .HSYNC_N(hsn1), .HBLANK(hb1),
    .HBLANK_N(hbn1), .VSYNC(vs1), .VSYNC_N(vsn1), .VBLANK(vb1), .VBLANK_N(vbn1));

  videosync_gen #(.H_TOTAL(16), .V_TOTAL(20), .H_BLANK_START(0), .H_BLANK_END(8),
                  .H_SYNC_START(2), .H_SYNC_END(5), .HBLANK_DELAY(2)) dut2 (
    .CLK_DRV(clk), .RESET(rst), .CE_PIX(ce), .HCOUNT(hc2), .VCOUNT(vc2),
    .HRESET(hr2), .VRESET(vr2), .HSYNC(hs2), .HSYNC_N(hsn2), .HBLANK(hb2),
    .HBLANK_N(hbn2), .VSYNC(vs2), .VSYNC_N(vsn2), .VBLANK(vb2), .VBLANK_N(vbn2));

  // Reference state: counters, strobes, internal HBLANK and its delay history.
  int m_h0, m_v0, m_h2, m_v2;
  logic m_hr0, m_vr0, m_hr2, m_vr2;
  logic m_hb0, m_hb1, m_hb2;
  logic [4:0] m_dl0;
  logic [1:0] m_dl2;

  function automatic logic win(input int c, input int s, input int e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  task automatic tick;
    logic ce_s, rst_s;
    ce_s = ce;
    rst_s = rst;
    @(posedge clk);
    if (rst_s) begin
      m_h0 = 0; m_v0 = 0; m_h2 = 0; m_v2 = 0;
      m_hr0 = 0; m_vr0 = 0; m_hr2 = 0; m_vr2 = 0;
      m_hb0 = 0; m_hb1 = 0; m_hb2 = 0; m_dl0 = '0; m_dl2 = '0;
    end else begin
      m_dl0 = {m_dl0[3:0], m_hb0};
      m_dl2 = {m_dl2[0], m_hb2};
      m_hr0 = 0; m_vr0 = 0; m_hr2 = 0; m_vr2 = 0;
      if (ce_s) begin
        m_hr0 = (m_h0 == 454);
        m_vr0 = m_hr0 && (m_v0 == 261);
        if (m_hr0) begin m_h0 = 0; m_v0 = (m_v0 == 261) ? 0 : m_v0 + 1; end
        else m_h0++;
        m_hr2 = (m_h2 == 15);
        m_vr2 = m_hr2 && (m_v2 == 19);
        if (m_hr2) begin m_h2 = 0; m_v2 = (m_v2 == 19) ? 0 : m_v2 + 1; end
        else m_h2++;
        m_hb0 = win(m_h0, 0, 80);
        m_hb1 = win(m_h0, 440, 20);
        m_hb2 = win(m_h2, 0, 8);
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ce = 1'b1;
    repeat (3) tick();
    checks++; if (hc0 !== 9'd0 || vc0 !== 9'd0) begin
      errors++; $display("FAIL reset_count: got %0d,%0d want 0,0", hc0, vc0); end
    checks++; if ({hr0, vr0} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes: got %b want 00", {hr0, vr0}); end
    checks++; if ({hs0, hb0, vs0, vb0} !== 4'b0000) begin
      errors++; $display("FAIL reset_true_flags: got %b want 0000", {hs0, hb0, vs0, vb0}); end
    checks++; if ({hsn0, hbn0, vsn0, vbn0} !== 4'b1111) begin
      errors++; $display("FAIL reset_n_flags: got %b want 1111", {hsn0, hbn0, vsn0, vbn0}); end
    checks++; if ({hb1, hb2, hbn1, hbn2} !== 4'b0011) begin
      errors++; $display("FAIL reset_hblank_other: got %b want 0011", {hb1, hb2, hbn1, hbn2}); end
  endtask

  task automatic test_line;
    int pulses = 0;
    int ph = -1, pv = -1;
    rst = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 455; i++) begin
      tick();
      checks++; if (hc0 !== 9'(m_h0) || vc0 !== 9'(m_v0)) begin
        errors++; $display("FAIL line_count: got %0d,%0d want %0d,%0d", hc0, vc0, m_h0, m_v0); end
      checks++; if (hr0 !== m_hr0) begin
        errors++; $display("FAIL line_hreset: got %b want %b at h=%0d", hr0, m_hr0, m_h0); end
      if (hr0 === 1'b1) begin pulses++; ph = int'(hc0); pv = int'(vc0); end
    end
    checks++; if (pulses != 1) begin
      errors++; $display("FAIL line_hreset_pulses: got %0d want 1", pulses); end
    checks++; if (ph != 0 || pv != 1) begin
      errors++; $display("FAIL line_hreset_pos: got %0d,%0d want 0,1", ph, pv); end
    checks++; if (hc0 !== 9'd0 || vc0 !== 9'd1) begin
      errors++; $display("FAIL line_end: got %0d,%0d want 0,1", hc0, vc0); end
  endtask

  task automatic test_hsync;
    int high0 = 0, high1 = 0, first = -1;
    for (int i = 0; i < 455; i++) begin
      tick();
      checks++; if (hs0 !== win(m_h0, 32, 64)) begin
        errors++; $display("FAIL hsync: got %b want %b at h=%0d", hs0, win(m_h0, 32, 64), m_h0); end
      checks++; if (hsn0 !== ~hs0) begin
        errors++; $display("FAIL hsync_n: got %b want %b", hsn0, ~hs0); end
      checks++; if (hs2 !== win(m_h2, 2, 5) || hsn2 !== ~hs2) begin
        errors++; $display("FAIL hsync_small: got %b/%b at h=%0d", hs2, hsn2, m_h2); end
      if (hs0 === 1'b1) begin high0++; if (first < 0) first = int'(hc0); end
      if (hs1 === 1'b1) high1++;
    end
    checks++; if (high0 != 32 || first != 32) begin
      errors++; $display("FAIL hsync_width: got %0d from %0d want 32 from 32", high0, first); end
    checks++; if (high1 != 0) begin
      errors++; $display("FAIL hsync_empty_window: got %0d want 0", high1); end
  endtask

  task automatic test_hblank;
    int rise = -1, fall = -1, high1 = 0;
    logic prev;
    prev = hb0;
    for (int i = 0; i < 455; i++) begin
      tick();
      checks++; if (hb0 !== m_dl0[4] || hbn0 !== ~m_dl0[4]) begin
        errors++; $display("FAIL hblank_dly: got %b/%b want %b at h=%0d", hb0, hbn0, m_dl0[4], m_h0); end
      checks++; if (hb1 !== m_hb1 || hbn1 !== ~m_hb1) begin
        errors++; $display("FAIL hblank_wrap: got %b/%b want %b at h=%0d", hb1, hbn1, m_hb1, m_h0); end
      checks++; if (hb2 !== m_dl2[1]) begin
        errors++; $display("FAIL hblank_small: got %b want %b", hb2, m_dl2[1]); end
      if (hb0 === 1'b1 && prev === 1'b0) rise = int'(hc0);
      if (hb0 === 1'b0 && prev === 1'b1) fall = int'(hc0);
      if (hb1 === 1'b1) high1++;
      prev = hb0;
    end
    checks++; if (rise != 5 || fall != 85) begin
      errors++; $display("FAIL hblank_edges: got rise %0d fall %0d want 5 and 85", rise, fall); end
    checks++; if (high1 != 35) begin
      errors++; $display("FAIL hblank_wrap_width: got %0d want 35", high1); end
  endtask

  task automatic test_frame;
    int vpulses = 0, vbn = 0, vsn = 0;
    logic pvb, pvs;
    pvb = vb2;
    pvs = vs2;
    for (int i = 0; i < 320; i++) begin
      tick();
      checks++; if (vb2 !== win(m_v2, 0, 16) || vbn2 !== ~vb2) begin
        errors++; $display("FAIL vblank: got %b/%b at v=%0d", vb2, vbn2, m_v2); end
      checks++; if (vs2 !== win(m_v2, 12, 16) || vsn2 !== ~vs2) begin
        errors++; $display("FAIL vsync: got %b/%b at v=%0d", vs2, vsn2, m_v2); end
      checks++; if (vr2 !== m_vr2 || hr2 !== m_hr2) begin
        errors++; $display("FAIL frame_strobes: got %b%b want %b%b", vr2, hr2, m_vr2, m_hr2); end
      checks++; if ((vb2 !== pvb || vs2 !== pvs) && hc2 !== 9'd0) begin
        errors++; $display("FAIL vflag_midline: changed at h=%0d want h=0", hc2); end
      checks++; if (vb0 !== win(m_v0, 0, 16) || vs0 !== win(m_v0, 12, 16)) begin
        errors++; $display("FAIL vflags_default: got %b%b at v=%0d", vb0, vs0, m_v0); end
      if (vr2 === 1'b1) begin
        vpulses++;
        checks++; if (hr2 !== 1'b1 || hc2 !== 9'd0 || vc2 !== 9'd0) begin
          errors++; $display("FAIL vreset_pos: got hr=%b %0d,%0d want 1 0,0", hr2, hc2, vc2); end
      end
      if (vb2 === 1'b1) vbn++;
      if (vs2 === 1'b1) vsn++;
      pvb = vb2;
      pvs = vs2;
    end
    checks++; if (vpulses != 1) begin
      errors++; $display("FAIL vreset_pulses: got %0d want 1", vpulses); end
    checks++; if (vbn != 256 || vsn != 64) begin
      errors++; $display("FAIL vflag_widths: got %0d/%0d want 256/64", vbn, vsn); end
  endtask

  task automatic test_ce_reset;
    logic hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      ce = (i % 4 == 0);
      tick();
      checks++; if (hc0 !== 9'(m_h0) || vc0 !== 9'(m_v0) || hr0 !== m_hr0) begin
        errors++; $display("FAIL ce_count: got %0d,%0d,%b want %0d,%0d,%b",
                           hc0, vc0, hr0, m_h0, m_v0, m_hr0); end
      if (hc0 === 9'd100) hit = 1'b1;
    end
    checks++; if (!hit) begin
      errors++; $display("FAIL ce_timeout: HCOUNT never reached 100, got %0d", hc0); end
    ce = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (hc0 !== 9'd0 || vc0 !== 9'd0) begin
      errors++; $display("FAIL async_reset_count: got %0d,%0d want 0,0", hc0, vc0); end
    checks++; if ({vb0, vbn0, hsn0, hbn0} !== 4'b0111) begin
      errors++; $display("FAIL async_reset_flags: got %b want 0111", {vb0, vbn0, hsn0, hbn0}); end
    tick();
    rst = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (hc0 !== 9'(i + 1) || vc0 !== 9'd0) begin
        errors++; $display("FAIL restart_count: got %0d,%0d want %0d,0", hc0, vc0, i + 1); end
      checks++; if (hb0 !== (i == 5)) begin
        errors++; $display("FAIL restart_hblank: got %b want %b at tick %0d", hb0, (i == 5), i + 1); end
      checks++; if (hb1 !== 1'b1) begin
        errors++; $display("FAIL restart_hblank_nodelay: got %b want 1", hb1); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_hsync();
    test_hblank();
    test_frame();
    test_ce_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
